not_edge_monitor: RTL and testbench



---
 rtl/not_edge_monitor_pkg.sv | 12 +
 rtl/not_edge_monitor_bit_synchronizer.sv | 25 ++
 rtl/not_edge_monitor.sv | 128 ++++++++++++
 tb/tb_not_edge_monitor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/not_edge_monitor_pkg.sv
// Shared types and default parameters for the not_switch output monitor.
package not_edge_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_FILTER_CYCLES = 3;

endpackage : not_edge_pkg

// File: rtl/not_edge_monitor_bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last stage.
module bit_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Plain shift chain, no logic between stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/not_edge_monitor.sv
// Synchronizes the inverter output, filters glitches, and reports level,
// edge pulses and saturating rise/fall event counters.
module not_edge_monitor
  import not_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter logic        RESET_LEVEL   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  input  logic                 clear,
  output logic                 level,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] rise_count,
  output logic [CNT_WIDTH-1:0] fall_count,
  output logic                 overflow
);

  localparam int unsigned           STAB_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

  logic                 w_s;
  logic                 w_diff;
  logic                 w_toggle;
  logic                 w_rise;
  logic                 w_fall;

  state_e               r_state;
  logic [STAB_W-1:0]    r_stab_cnt;
  logic                 r_level;
  logic                 r_rise_pulse;
  logic                 r_fall_pulse;
  logic [CNT_WIDTH-1:0] r_rise_count;
  logic [CNT_WIDTH-1:0] r_fall_count;
  logic                 r_overflow;

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (w_s)
  );

  // A toggle is accepted when the new value has been seen FILTER_CYCLES times.
  assign w_diff   = (w_s != r_level);
  assign w_toggle = w_diff &&
                    (((r_state == STABLE) && (FILTER_CYCLES == 1)) ||
                     ((r_state == CHECK)  && (r_stab_cnt == STAB_LAST)));
  assign w_rise   = w_toggle && !r_level;
  assign w_fall   = w_toggle &&  r_level;

  // Stability filter FSM with registered level and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= STABLE;
      r_stab_cnt   <= '0;
      r_level      <= RESET_LEVEL;
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
    end else begin
      r_rise_pulse <= w_rise;
      r_fall_pulse <= w_fall;
      if (r_state == STABLE) begin
        if (w_toggle) begin
          r_level <= ~r_level;
        end else if (w_diff) begin
          r_state    <= CHECK;
          r_stab_cnt <= STAB_W'(1);
        end
      end else begin
        if (!w_diff) begin
          r_state    <= STABLE;
          r_stab_cnt <= '0;
        end else if (w_toggle) begin
          r_level    <= ~r_level;
          r_state    <= STABLE;
          r_stab_cnt <= '0;
        end else begin
          r_stab_cnt <= r_stab_cnt + STAB_W'(1);
        end
      end
    end
  end

  // Saturating event counters; clear still lets a same-cycle edge count once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise_count <= '0;
      r_fall_count <= '0;
      r_overflow   <= 1'b0;
    end else if (clear) begin
      r_rise_count <= CNT_WIDTH'(w_rise);
      r_fall_count <= CNT_WIDTH'(w_fall);
      r_overflow   <= 1'b0;
    end else begin
      if (w_rise) begin
        if (r_rise_count == CNT_MAX) begin
          r_overflow <= 1'b1;
        end else begin
          r_rise_count <= r_rise_count + CNT_WIDTH'(1);
        end
      end
      if (w_fall) begin
        if (r_fall_count == CNT_MAX) begin
          r_overflow <= 1'b1;
        end else begin
          r_fall_count <= r_fall_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign level      = r_level;
  assign rise_pulse = r_rise_pulse;
  assign fall_pulse = r_fall_pulse;
  assign rise_count = r_rise_count;
  assign fall_count = r_fall_count;
  assign overflow   = r_overflow;

endmodule : not_edge_monitor

// File: tb/tb_not_edge_monitor.sv
// Directed bench for not_edge_monitor: per-cycle vector table plus corner sequences.
module tb_not_edge_monitor;

  logic clk;
  logic reset;
  logic in;
  logic clear;

  logic       level, rise_pulse, fall_pulse, overflow;
  logic [7:0] rise_count, fall_count;

  logic       l2, rp2, fp2, ov2;
  logic [1:0] rc2, fc2;

  logic       l3, rp3, fp3, ov3;
  logic [7:0] rc3, fc3;

  int n_pass;
  int n_total;

  not_edge_monitor dut (
    .clk(clk), .reset(reset), .in(in), .clear(clear),
    .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .rise_count(rise_count), .fall_count(fall_count), .overflow(overflow)
  );

  not_edge_monitor #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in(in), .clear(clear),
    .level(l2), .rise_pulse(rp2), .fall_pulse(fp2),
    .rise_count(rc2), .fall_count(fc2), .overflow(ov2)
  );

  not_edge_monitor #(.FILTER_CYCLES(1)) dut_f1 (
    .clk(clk), .reset(reset), .in(in), .clear(clear),
    .level(l3), .rise_pulse(rp3), .fall_pulse(fp3),
    .rise_count(rc3), .fall_count(fc3), .overflow(ov3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       in_v;
    logic       clr;
    logic       lvl;
    logic       rp;
    logic       fp;
    logic [7:0] rc;
    logic [7:0] fc;
    logic       ov;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic i, input logic c, input logic l,
                              input logic r, input logic f,
                              input logic [7:0] rc, input logic [7:0] fc,
                              input logic ov);
    vec_t v;
    v.in_v = i; v.clr = c; v.lvl = l; v.rp = r; v.fp = f;
    v.rc = rc; v.fc = fc; v.ov = ov;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Idle high, then clean fall, 2-cycle high glitch, 3-cycle high pulse, clear.
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
    vecs[20] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0);
    vecs[22] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0);
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 1'b0);
    vecs[24] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2, 1'b0);
    vecs[25] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

    reset = 1'b1;
    in    = 1'b1;
    clear = 1'b0;
    tick();
    tick();
    chk("reset_state", {level, rise_pulse, fall_pulse, rise_count, fall_count, overflow},
        {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0});
    chk("reset_state_cw2", {l2, rp2, fp2, rc2, fc2, ov2}, {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0});
    chk("reset_state_f1", {l3, rp3, fp3, ov3}, {1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      in    = vecs[i].in_v;
      clear = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d", i),
          {level, rise_pulse, fall_pulse, rise_count, fall_count, overflow},
          {vecs[i].lvl, vecs[i].rp, vecs[i].fp, vecs[i].rc, vecs[i].fc, vecs[i].ov});
    end
    clear = 1'b0;

    // Five clean rising edges on the 2-bit counter instance.
    for (int k = 0; k < 5; k++) begin
      in = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      chk($sformatf("sat%0d_pre_level", k), 32'(level), 32'd0);
      tick();
      chk($sformatf("sat%0d_rise_pulse", k), 32'(rise_pulse), 32'd1);
      chk($sformatf("sat%0d_rc2", k), 32'(rc2), (k < 3) ? 32'(k + 1) : 32'd3);
      chk($sformatf("sat%0d_ov2", k), 32'(ov2), (k >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("sat%0d_rc8", k), 32'(rise_count), 32'(k + 1));
      in = 1'b0;
      for (int e = 1; e <= 6; e++) tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_cw2", {30'd0, rc2, fc2, ov2, l2}, {30'd0, 2'd0, 2'd0, 1'b0, 1'b0});
    chk("clear_level", 32'(level), 32'd0);

    // Clear coinciding with an accepted falling edge.
    in = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    chk("pre_clrfall_level", 32'(level), 32'd1);
    in = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrfall_dut", {fall_pulse, rise_count, fall_count, overflow},
        {1'b1, 8'd0, 8'd1, 1'b0});
    chk("clrfall_cw2", {fp2, rc2, fc2, ov2}, {1'b1, 2'd0, 2'd1, 1'b0});
    tick();
    chk("clrfall_pulse_width", 32'(fall_pulse), 32'd0);

    // Reset two cycles into CHECK, then full latency on a fresh edge.
    in = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    chk("pre_rst_level", 32'(level), 32'd1);
    in = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_check", {level, rise_pulse, fall_pulse, rise_count, fall_count, overflow},
        {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0});
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("post_rst_e%0d", e), {30'd0, level, fall_pulse},
          (e == 5) ? 32'b01 : 32'b10);
      chk($sformatf("f1_e%0d", e), {30'd0, l3, fp3},
          (e == 3) ? 32'b01 : ((e > 3) ? 32'b00 : 32'b10));
    end
    chk("post_rst_fall_count", 32'(fall_count), 32'd1);
    tick();
    chk("post_rst_pulse_width", 32'(fall_pulse), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_not_edge_monitor
